// File: rtl/sin_cos_iq_demod.sv
// Quadrature I/Q demodulator: integrates SAMPLE*COS and SAMPLE*SIN over a window of N valid samples.
// Define SIN_COS_IQ_DEMOD_SATURATE_EN for saturating accumulators and a sticky OVERFLOW flag.
module sin_cos_iq_demod #(
  parameter int SAMPLE_BITS = 12,
  parameter int REF_BITS    = 13,
  parameter int ACC_BITS    = 48,
  parameter int PERIOD_BITS = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          CE,
  input  logic signed [SAMPLE_BITS-1:0] SAMPLE_IN,
  input  logic                          SAMPLE_VALID,
  input  logic signed [REF_BITS-1:0]    SIN_IN,
  input  logic signed [REF_BITS-1:0]    COS_IN,
  input  logic        [PERIOD_BITS-1:0] PERIOD_IN,
  input  logic                          PERIOD_WE,
  output logic signed [ACC_BITS-1:0]    I_OUT,
  output logic signed [ACC_BITS-1:0]    Q_OUT,
  output logic                          OUT_VALID,
  output logic                          OVERFLOW
);

  localparam int PROD_BITS = SAMPLE_BITS + REF_BITS;
  localparam logic [PERIOD_BITS-1:0] CNT_ONE = 1;

  // Stream contract: SAMPLE_VALID qualifies SAMPLE_IN/SIN_IN/COS_IN on one CE-enabled cycle and there
  // is no backpressure; OUT_VALID likewise qualifies I_OUT/Q_OUT for exactly one CE-enabled cycle.

  logic        [PERIOD_BITS-1:0] period;
  logic        [PERIOD_BITS-1:0] count;
  logic                          s1_valid;
  logic signed [SAMPLE_BITS-1:0] s1_sample;
  logic signed [REF_BITS-1:0]    s1_sin;
  logic signed [REF_BITS-1:0]    s1_cos;
  logic signed [PROD_BITS-1:0]   s1_sample_x;
  logic signed [PROD_BITS-1:0]   s1_sin_x;
  logic signed [PROD_BITS-1:0]   s1_cos_x;
  logic signed [PROD_BITS-1:0]   ps_full;
  logic signed [PROD_BITS-1:0]   pc_full;
  logic signed [ACC_BITS-1:0]    ps_ext;
  logic signed [ACC_BITS-1:0]    pc_ext;
  logic                          s2_valid;
  logic signed [ACC_BITS-1:0]    s2_ps;
  logic signed [ACC_BITS-1:0]    s2_pc;
  logic signed [ACC_BITS-1:0]    acc_i;
  logic signed [ACC_BITS-1:0]    acc_q;
  logic signed [ACC_BITS-1:0]    sum_i;
  logic signed [ACC_BITS-1:0]    sum_q;
  logic                          out_pulse;

  // Operands are widened to the full product width so the multiply is exact at that width.
  assign s1_sample_x = {{REF_BITS{s1_sample[SAMPLE_BITS-1]}}, s1_sample};
  assign s1_sin_x    = {{SAMPLE_BITS{s1_sin[REF_BITS-1]}}, s1_sin};
  assign s1_cos_x    = {{SAMPLE_BITS{s1_cos[REF_BITS-1]}}, s1_cos};
  assign ps_full     = s1_sample_x * s1_sin_x;
  assign pc_full     = s1_sample_x * s1_cos_x;

  generate
    if (ACC_BITS > PROD_BITS) begin : g_ext
      assign ps_ext = {{(ACC_BITS-PROD_BITS){ps_full[PROD_BITS-1]}}, ps_full};
      assign pc_ext = {{(ACC_BITS-PROD_BITS){pc_full[PROD_BITS-1]}}, pc_full};
    end else begin : g_noext
      assign ps_ext = ps_full;
      assign pc_ext = pc_full;
    end
  endgenerate

`ifdef SIN_COS_IQ_DEMOD_SATURATE_EN
  localparam logic signed [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

  logic signed [ACC_BITS:0] wide_i;
  logic signed [ACC_BITS:0] wide_q;
  logic                     sat_i;
  logic                     sat_q;
  logic                     ovf_flag;

  // One guard bit detects two's-complement overflow; clamp toward the sign of the true sum.
  always_comb begin
    wide_i = {acc_i[ACC_BITS-1], acc_i} + {s2_pc[ACC_BITS-1], s2_pc};
    wide_q = {acc_q[ACC_BITS-1], acc_q} + {s2_ps[ACC_BITS-1], s2_ps};
    sat_i  = wide_i[ACC_BITS] != wide_i[ACC_BITS-1];
    sat_q  = wide_q[ACC_BITS] != wide_q[ACC_BITS-1];
    sum_i  = sat_i ? (wide_i[ACC_BITS] ? ACC_MIN : ACC_MAX) : wide_i[ACC_BITS-1:0];
    sum_q  = sat_q ? (wide_q[ACC_BITS] ? ACC_MIN : ACC_MAX) : wide_q[ACC_BITS-1:0];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ovf_flag <= 1'b0;
    end else if (CE) begin
      if (PERIOD_WE) begin
        ovf_flag <= 1'b0;
      end else if (s2_valid && (sat_i || sat_q)) begin
        ovf_flag <= 1'b1;
      end
    end
  end

  assign OVERFLOW = ovf_flag;
`else
  assign sum_i    = acc_i + s2_pc;
  assign sum_q    = acc_q + s2_ps;
  assign OVERFLOW = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      period    <= '0;
      count     <= '0;
      s1_valid  <= 1'b0;
      s1_sample <= '0;
      s1_sin    <= '0;
      s1_cos    <= '0;
      s2_valid  <= 1'b0;
      s2_ps     <= '0;
      s2_pc     <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      I_OUT     <= '0;
      Q_OUT     <= '0;
      out_pulse <= 1'b0;
    end else if (CE) begin
      s1_sample <= SAMPLE_IN;
      s1_sin    <= SIN_IN;
      s1_cos    <= COS_IN;
      s2_ps     <= ps_ext;
      s2_pc     <= pc_ext;
      out_pulse <= 1'b0;
      if (PERIOD_WE) begin
        // A window restart discards everything in flight, including a sample offered this cycle.
        period   <= PERIOD_IN;
        count    <= '0;
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
        acc_i    <= '0;
        acc_q    <= '0;
      end else begin
        s1_valid <= SAMPLE_VALID && (period != '0);
        s2_valid <= s1_valid;
        if (s2_valid) begin
          if (count == period - CNT_ONE) begin
            I_OUT     <= sum_i;
            Q_OUT     <= sum_q;
            out_pulse <= 1'b1;
            acc_i     <= '0;
            acc_q     <= '0;
            count     <= '0;
          end else begin
            acc_i <= sum_i;
            acc_q <= sum_q;
            count <= count + CNT_ONE;
          end
        end
      end
    end
  end

  // A pulse registered just before CE drops is held and only shown on the next CE-enabled cycle.
  assign OUT_VALID = out_pulse & CE;

endmodule

// File: tb/tb_sin_cos_iq_demod.sv
// Self-checking bench for sin_cos_iq_demod: table vectors, hand sequences for corner cases,
// and randomized windows checked against a plain-arithmetic reference model.
module tb_sin_cos_iq_demod;

  localparam int SB = 12;
  localparam int RB = 13;
  localparam int AB = 25;
  localparam int PB = 16;
  localparam int CYCLE_LIMIT = 50000;
  localparam longint ACC_MAX = (longint'(1) <<< (AB-1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (AB-1));
  localparam longint ACC_MOD = longint'(1) <<< AB;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 ce = 1'b0;
  logic                 sample_valid = 1'b0;
  logic                 period_we = 1'b0;
  logic signed [SB-1:0] sample_in = '0;
  logic signed [RB-1:0] sin_in = '0;
  logic signed [RB-1:0] cos_in = '0;
  logic [PB-1:0]        period_in = '0;
  logic signed [AB-1:0] i_out;
  logic signed [AB-1:0] q_out;
  logic                 out_valid;
  logic                 overflow;

  sin_cos_iq_demod #(
    .SAMPLE_BITS(SB), .REF_BITS(RB), .ACC_BITS(AB), .PERIOD_BITS(PB)
  ) dut (
    .CLK(clk), .RESET(rst), .CE(ce),
    .SAMPLE_IN(sample_in), .SAMPLE_VALID(sample_valid),
    .SIN_IN(sin_in), .COS_IN(cos_in),
    .PERIOD_IN(period_in), .PERIOD_WE(period_we),
    .I_OUT(i_out), .Q_OUT(q_out), .OUT_VALID(out_valid), .OVERFLOW(overflow)
  );

  // ---------------- clock / time limit ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #(CYCLE_LIMIT * 10);
    $display("FAIL time_limit: got no end of test after %0d cycles, required completion", CYCLE_LIMIT);
    $fatal(1, "time limit reached");
  end

  // ---------------- scoreboard state ----------------
  int               n_checks = 0;
  int               n_fail = 0;
  int               pulse_cnt = 0;
  logic [2*AB-1:0]  exp_q[$];
  logic [2*AB-1:0]  mon_e;

  // reference model state: window integration with plain integer arithmetic
  bit     model_on = 1'b0;
  int     m_period = 0;
  int     m_cnt = 0;
  longint m_acc_i = 0;
  longint m_acc_q = 0;
  bit     m_ovf = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic longint fold(input longint v, output bit sat);
    longint m;
    sat = 1'b0;
`ifdef SIN_COS_IQ_DEMOD_SATURATE_EN
    m = v;
    if (v > ACC_MAX) begin m = ACC_MAX; sat = 1'b1; end
    if (v < ACC_MIN) begin m = ACC_MIN; sat = 1'b1; end
`else
    m = v & (ACC_MOD - 1);
    if (m > ACC_MAX) m = m - ACC_MOD;
`endif
    return m;
  endfunction

  function automatic void push_exp(input longint ei, input longint eq);
    logic [AB-1:0] a;
    logic [AB-1:0] b;
    a = ei[AB-1:0];
    b = eq[AB-1:0];
    exp_q.push_back({a, b});
  endfunction

  function automatic void model_push(input int s, input int co, input int sn);
    bit si;
    bit sq;
    if (m_period == 0) return;
    m_acc_i = fold(m_acc_i + longint'(s) * longint'(co), si);
    m_acc_q = fold(m_acc_q + longint'(s) * longint'(sn), sq);
    if (si || sq) m_ovf = 1'b1;
    m_cnt++;
    if (m_cnt == m_period) begin
      push_exp(m_acc_i, m_acc_q);
      m_acc_i = 0;
      m_acc_q = 0;
      m_cnt = 0;
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got OUT_VALID=1 with I_OUT=%0d Q_OUT=%0d, required no pulse", i_out, q_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("i_out", i_out, $signed(mon_e[2*AB-1:AB]));
        check("q_out", q_out, $signed(mon_e[AB-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit c_e, input bit v, input int s, input int co, input int sn);
    @(posedge clk); #2;
    ce = c_e;
    period_we = 1'b0;
    sample_valid = v;
    sample_in = s[SB-1:0];
    cos_in = co[RB-1:0];
    sin_in = sn[RB-1:0];
    if (model_on && c_e && v) model_push(s, co, sn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic write_period(input int p, input bit v, input int s, input int co, input int sn);
    @(posedge clk); #2;
    ce = 1'b1;
    period_we = 1'b1;
    period_in = p[PB-1:0];
    sample_valid = v;
    sample_in = s[SB-1:0];
    cos_in = co[RB-1:0];
    sin_in = sn[RB-1:0];
    m_period = p;
    m_cnt = 0;
    m_acc_i = 0;
    m_acc_q = 0;
    m_ovf = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int     period;
    int     s;
    int     c;
    int     sn;
    longint exp_i;
    longint exp_q;
    bit     exp_ovf;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];

  initial begin
    int p0;
    int p;
    int nsamp;

    vecs[0] = '{4, 100, 1000, 0, 400000, 0, 1'b0};
`ifdef SIN_COS_IQ_DEMOD_SATURATE_EN
    vecs[1] = '{3, 2047, 4095, 0, 16777215, 0, 1'b1};
`else
    vecs[1] = '{3, 2047, 4095, 0, -8407037, 0, 1'b0};
`endif
    vecs[2] = '{1, -2048, -4096, 4095, 8388608, -8386560, 1'b0};
    vecs[3] = '{5, -7, 3, -11, -105, 385, 1'b0};
    vecs[4] = '{2, 2047, -4096, -4096, -16769024, -16769024, 1'b0};
`ifdef SIN_COS_IQ_DEMOD_SATURATE_EN
    vecs[5] = '{3, -2048, -4096, 4095, 16777215, -16777216, 1'b1};
`else
    vecs[5] = '{3, -2048, -4096, 4095, -8388608, 8394752, 1'b0};
`endif

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_i_out", i_out, 0);
    check("reset_q_out", q_out, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_overflow", overflow, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // period==0 after reset: samples are ignored
    p0 = pulse_cnt;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 9, 9, 9);
    idle(5);
    check("idle_period0_pulses", pulse_cnt - p0, 0);

    // table vectors: constant-sample full windows
    for (int k = 0; k < NV; k++) begin
      p0 = pulse_cnt;
      write_period(vecs[k].period, 1'b0, 0, 0, 0);
      push_exp(vecs[k].exp_i, vecs[k].exp_q);
      for (int j = 0; j < vecs[k].period; j++) cyc(1'b1, 1'b1, vecs[k].s, vecs[k].c, vecs[k].sn);
      idle(5);
      check($sformatf("vec%0d_pulses", k), pulse_cnt - p0, 1);
      check($sformatf("vec%0d_overflow", k), overflow, vecs[k].exp_ovf);
      check($sformatf("vec%0d_drained", k), exp_q.size(), 0);
    end

    // signs and bubbles
    p0 = pulse_cnt;
    write_period(2, 1'b0, 0, 0, 0);
    push_exp(8388609, -8386561);
    cyc(1'b1, 1'b1, -2048, -4096, 4095);
    idle(3);
    cyc(1'b1, 1'b1, 1, 1, -1);
    idle(5);
    check("bubbles_pulses", pulse_cnt - p0, 1);

    // restart mid-window; the sample sharing the write cycle is dropped
    p0 = pulse_cnt;
    write_period(4, 1'b0, 0, 0, 0);
    cyc(1'b1, 1'b1, 50, 50, 50);
    cyc(1'b1, 1'b1, 50, 50, 50);
    write_period(3, 1'b1, 99, 99, 99);
    push_exp(300, -120);
    for (int j = 0; j < 3; j++) cyc(1'b1, 1'b1, 10, 10, -4);
    idle(5);
    check("restart_pulses", pulse_cnt - p0, 1);

    // a window completing in flight is discarded by a period write
    p0 = pulse_cnt;
    write_period(1, 1'b0, 0, 0, 0);
    cyc(1'b1, 1'b1, 3, 3, 3);
    write_period(1, 1'b0, 0, 0, 0);
    idle(5);
    check("inflight_discard_pulses", pulse_cnt - p0, 0);

    // CE pause before the pulse is formed, and with the pulse already pending
    for (int d = 0; d <= 2; d += 2) begin
      p0 = pulse_cnt;
      write_period(1, 1'b0, 0, 0, 0);
      push_exp(35, 0);
      cyc(1'b1, 1'b1, 5, 7, 0);
      idle(d);
      for (int i = 0; i < 5; i++) begin
        cyc(1'b0, 1'b0, 0, 0, 0);
        @(negedge clk);
        check($sformatf("ce_low_out_valid_d%0d", d), out_valid, 0);
      end
      idle(5);
      check($sformatf("ce_pause_pulses_d%0d", d), pulse_cnt - p0, 1);
    end

    // asynchronous reset mid-window
    write_period(3, 1'b0, 0, 0, 0);
    cyc(1'b1, 1'b1, 1, 1, 1);
    cyc(1'b1, 1'b1, 1, 1, 1);
    check("pre_reset_i_out", i_out, 35);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_i_out", i_out, 0);
    check("async_reset_q_out", q_out, 0);
    check("async_reset_out_valid", out_valid, 0);
    check("async_reset_overflow", overflow, 0);
    exp_q.delete();
    m_period = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 4, 4, 4);
    idle(5);
    check("post_reset_idle_pulses", pulse_cnt - p0, 0);

    // randomized windows against the reference model
    model_on = 1'b1;
    for (int r = 0; r < 10; r++) begin
      p = int'($urandom_range(1, 6));
      write_period(p, 1'b0, 0, 0, 0);
      nsamp = int'($urandom_range(p, 4 * p + 3));
      for (int j = 0; j < nsamp; j++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        if ($urandom_range(0, 5) == 0) cyc(1'b0, 1'b1, 77, 77, 77);
        cyc(1'b1, 1'b1, int'($urandom_range(0, 4095)) - 2048,
            int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 8191)) - 4096);
      end
      idle(5);
      check($sformatf("rand%0d_drained", r), exp_q.size(), 0);
      check($sformatf("rand%0d_overflow", r), overflow, m_ovf);
    end
    model_on = 1'b0;

    check("final_exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sin_cos_iq_demod.md
Name: sin_cos_iq_demod

Overview:
Quadrature demodulator that consumes the signed SIN/COS reference from the sine/cosine DCO together with a signed sensor ADC sample stream.
- Multiplies each valid sample by COS (I) and SIN (Q).
- Integrates the products over a programmable window of N valid samples.
- Emits one I/Q result pair per window.
- Sits between the DCO/ADC front end and the sensor measurement logic.

Parameters:
SAMPLE_BITS, 12, width of signed ADC sample
REF_BITS, 13, width of signed SIN/COS reference; must match the DCO table data width
ACC_BITS, 48, width of signed I/Q accumulators; must be >= SAMPLE_BITS+REF_BITS
PERIOD_BITS, 16, width of the integration window length register

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous reset, active high
CE  in  1  clock enable; 0 freezes all state
SAMPLE_IN  in  SAMPLE_BITS  signed ADC sample
SAMPLE_VALID  in  1  SAMPLE_IN/SIN_IN/COS_IN valid this cycle
SIN_IN  in  REF_BITS  signed sine reference, time-aligned with SAMPLE_IN
COS_IN  in  REF_BITS  signed cosine reference, time-aligned with SAMPLE_IN
PERIOD_IN  in  PERIOD_BITS  window length N in valid samples
PERIOD_WE  in  1  load PERIOD_IN and restart the window
I_OUT  out  ACC_BITS  signed sum of SAMPLE*COS over the last window
Q_OUT  out  ACC_BITS  signed sum of SAMPLE*SIN over the last window
OUT_VALID  out  1  one-cycle pulse; new I_OUT/Q_OUT available
OVERFLOW  out  1  sticky accumulator saturation flag (optional feature)

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active high. While RESET is asserted, all registers clear: period=0, window counter=0, accumulators=0, pipeline valid bits=0, I_OUT=0, Q_OUT=0, OUT_VALID=0, OVERFLOW=0.
- CE gating: every register updates only when CE=1. OUT_VALID is forced low while CE=0. A pending pulse is held and then asserted on the first cycle with CE=1, so the pulse lasts exactly one CE-enabled cycle.
- Pipeline, 3 stages:
  - S1: register sample, sin, cos, valid.
  - S2: register signed products ps=sample*sin and pc=sample*cos, each SAMPLE_BITS+REF_BITS wide, sign-extended to ACC_BITS.
  - S3: accumulate and count.
- Latency: the last sample of a window is captured at edge k. I_OUT/Q_OUT update and OUT_VALID goes high after edge k+2, i.e. 3 clock edges with CE=1.
- Window counter:
  - Counts S2-valid products only; bubbles (SAMPLE_VALID=0) are not counted and do not disturb accumulation.
  - On a valid product when count==period-1: I_OUT=accI+pc, Q_OUT=accQ+ps, OUT_VALID=1, accumulators←0, count←0.
  - Otherwise: acc+=product, count+=1.
- period==0 (reset state): block idle; samples are ignored, no accumulation, no output.
- PERIOD_WE (effective only when CE=1):
  - Loads period.
  - Clears accumulators, counter and all pipeline valid bits; in-flight samples are discarded.
  - No OUT_VALID for the partial window.
  - I_OUT/Q_OUT keep their last values.
- PERIOD_WE with SAMPLE_VALID in the same cycle: the write wins and that sample is discarded.
- period==1: every valid sample produces an output; back-to-back OUT_VALID pulses are allowed.
- Counter arithmetic: unsigned, PERIOD_BITS wide. The maximum window is 2^PERIOD_BITS-1.
- Accumulator arithmetic: two's complement, ACC_BITS wide. Overflow handling is set by the optional feature.

Optional Feature:
- Macro: SIN_COS_IQ_DEMOD_SATURATE_EN.
- When defined:
  - Each accumulator add saturates to +(2^(ACC_BITS-1)-1) or -2^(ACC_BITS-1).
  - Any saturation sets OVERFLOW, which stays 1 until RESET or PERIOD_WE.
  - The saturated value is the one reported in I_OUT/Q_OUT.
- When undefined:
  - Accumulators wrap modulo 2^ACC_BITS.
  - OVERFLOW is tied to 0.

Test Plan:
- Basic window: PERIOD=4; 4 consecutive valid samples with SAMPLE=100, COS=1000, SIN=0 -> after 3 edges past the 4th sample, one OUT_VALID pulse with I_OUT=400000, Q_OUT=0.
- Signs and bubbles: PERIOD=2; samples (-2048,cos=-4096,sin=4095) and (1,cos=1,sin=-1) separated by 3 invalid cycles -> I_OUT=8388609, Q_OUT=-8386561, exactly one pulse.
- Restart mid-window: PERIOD=4; 2 valid samples, then PERIOD_WE with PERIOD_IN=3 in the same cycle as a valid sample -> no pulse for the partial data; the next 3 valid samples (SAMPLE=10, COS=10) give I_OUT=300.
- CE pause: PERIOD=1; one valid sample (5, cos=7), then drop CE for 5 cycles starting at edge k+1 -> OUT_VALID stays low while CE=0, then pulses for one cycle after CE returns with I_OUT=35. A RESET asserted mid-window clears all outputs asynchronously.
- Saturation (macro defined, ACC_BITS=25): PERIOD=3; SAMPLE=2047, COS=4095 three times -> I_OUT=16777215, OVERFLOW=1 until the next PERIOD_WE. With the macro undefined, the same stimulus gives I_OUT=-8407037 and OVERFLOW=0.
